// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle add-class ops, iterative shift-add multiply.
// Define SEQ_ALU_DIV_EN to add opcode 0110 DIVU (restoring divide, quotient/remainder).
module seq_alu #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       inst,
  input  logic [WIDTH-1:0] ra,
  input  logic [WIDTH-1:0] rb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rd,
  output logic [WIDTH-1:0] rd_hi,
  output logic [7:0]       flags
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
`ifdef SEQ_ALU_DIV_EN
  localparam logic [1:0] S_DIV  = 2'd3;
  localparam logic [3:0] OP_DIVU = 4'b0110;
`endif

  localparam logic [3:0] OP_INC  = 4'b1000;
  localparam logic [3:0] OP_DEC  = 4'b1001;
  localparam logic [3:0] OP_ADD  = 4'b1010;
  localparam logic [3:0] OP_SUB  = 4'b1011;
  localparam logic [3:0] OP_MULU = 4'b0100;
  localparam logic [3:0] OP_MULS = 4'b0101;

  localparam int PW = 2 * WIDTH;

  function automatic logic [7:0] pack_flags(input logic c, input logic z, input logic n,
                                            input logic v, input logic d);
    return {3'b000, d, v, n, z, c};
  endfunction

  function automatic logic [WIDTH:0] add_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic cin);
    return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  endfunction

  // The most-negative value negates to itself, which read unsigned is the correct magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x,
                                                 input logic is_signed);
    return (is_signed && x[WIDTH-1]) ? $unsigned(-x) : $unsigned(x);
  endfunction

  function automatic logic [7:0] mul_flags(input logic [PW-1:0] p, input logic is_signed);
    logic z, fits;
    z    = (p == '0);
    fits = (&p[PW-1:WIDTH-1]) || !(|p[PW-1:WIDTH-1]);
    if (is_signed) return pack_flags(1'b0, z, p[PW-1], !fits, 1'b0);
    else           return pack_flags(|p[PW-1:WIDTH], z, 1'b0, 1'b0, 1'b0);
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             neg_q, neg_d;
  logic             muls_q, muls_d;
  logic [WIDTH-1:0] rd_q, rd_d;
  logic [WIDTH-1:0] rd_hi_q, rd_hi_d;
  logic [7:0]       flags_q, flags_d;

  logic [3:0]       op;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;
  logic             add_v;
  logic             op_signed;
  logic [PW-1:0]    mul_step;
  logic [PW-1:0]    mul_prod;
  logic             last_iter;
  logic             unused_inst;

  assign op          = inst[7:4];
  assign unused_inst = ^inst[3:0];
  assign op_signed   = (op == OP_MULS);

  always_comb begin
    add_b   = '0;
    add_cin = 1'b0;
    case (op)
      OP_INC:  add_cin = 1'b1;
      OP_DEC:  add_b   = '1;
      OP_ADD:  add_b   = rb;
      OP_SUB: begin
        add_b   = ~rb;
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  assign add_sum = add_fn(ra, add_b, add_cin);
  assign add_v   = (ra[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != ra[WIDTH-1]);

  assign mul_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_prod  = neg_q ? (~mul_step + PW'(1)) : mul_step;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef SEQ_ALU_DIV_EN
  // Trial subtract on the shifted-in remainder; the borrow bit decides the quotient bit.
  logic [WIDTH:0] div_trial;
  logic [PW-1:0]  div_step;
  assign div_trial = acc_q[PW-1:WIDTH-1] - {1'b0, mcand_q[WIDTH-1:0]};
  assign div_step  = div_trial[WIDTH] ? {acc_q[PW-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    muls_d   = muls_q;
    rd_d     = rd_q;
    rd_hi_d  = rd_hi_q;
    flags_d  = flags_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          case (op)
            OP_INC, OP_DEC, OP_ADD, OP_SUB: begin
              rd_d    = add_sum[WIDTH-1:0];
              rd_hi_d = '0;
              flags_d = pack_flags(add_sum[WIDTH], add_sum[WIDTH-1:0] == '0,
                                   add_sum[WIDTH-1], add_v, 1'b0);
              state_d = S_DONE;
            end
            OP_MULU, OP_MULS: begin
              muls_d   = op_signed;
              neg_d    = op_signed && (ra[WIDTH-1] ^ rb[WIDTH-1]);
              acc_d    = '0;
              mcand_d  = {{WIDTH{1'b0}}, magnitude(ra, op_signed)};
              mplier_d = magnitude(rb, op_signed);
              cnt_d    = '0;
              state_d  = S_MUL;
            end
`ifdef SEQ_ALU_DIV_EN
            OP_DIVU: begin
              if (rb == '0) begin
                rd_d    = '1;
                rd_hi_d = ra;
                flags_d = pack_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                state_d = S_DONE;
              end else begin
                acc_d   = {{WIDTH{1'b0}}, ra};
                mcand_d = {{WIDTH{1'b0}}, rb};
                cnt_d   = '0;
                state_d = S_DIV;
              end
            end
`endif
            default: begin
              rd_d    = '0;
              rd_hi_d = '0;
              flags_d = '0;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_MUL: begin
        acc_d    = mul_step;
        mcand_d  = {mcand_q[PW-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_iter) begin
          cnt_d   = '0;
          rd_d    = mul_prod[WIDTH-1:0];
          rd_hi_d = mul_prod[PW-1:WIDTH];
          flags_d = mul_flags(mul_prod, muls_q);
          state_d = S_DONE;
        end
      end
`ifdef SEQ_ALU_DIV_EN
      S_DIV: begin
        acc_d = div_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          cnt_d   = '0;
          rd_d    = div_step[WIDTH-1:0];
          rd_hi_d = div_step[PW-1:WIDTH];
          flags_d = pack_flags(1'b0, div_step[WIDTH-1:0] == '0, 1'b0, 1'b0, 1'b0);
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      muls_q   <= 1'b0;
      rd_q     <= '0;
      rd_hi_q  <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      muls_q   <= muls_d;
      rd_q     <= rd_d;
      rd_hi_q  <= rd_hi_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign rd        = rd_q;
  assign rd_hi     = rd_hi_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=8); build with +define+SEQ_ALU_DIV_EN to cover DIVU.
module tb_seq_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] inst;
  logic [7:0] ra;
  logic [7:0] rb;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] rd;
  logic [7:0] rd_hi;
  logic [7:0] flags;

  int checks = 0;
  int errors = 0;

  seq_alu #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inst      (inst),
    .ra        (ra),
    .rb        (rb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd        (rd),
    .rd_hi     (rd_hi),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait (bounded) for the result, check it, then complete the handshake.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input int exp_lat, input logic [7:0] exp_rd,
                        input logic [7:0] exp_hi, input logic [7:0] exp_fl,
                        input logic hold_ready);
    int lat;
    logic busy_ready;
    busy_ready = 1'b0;
    out_ready  = hold_ready;
    in_valid   = 1'b1;
    inst       = {op, 4'hF};
    ra         = a;
    rb         = b;
    tick();
    in_valid = 1'b0;
    ra       = 8'hA5;
    rb       = 8'h3C;
    inst     = 8'h00;
    lat      = 1;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_ready = 1'b1;
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 16'(lat), 16'(exp_lat));
    chk({tag, "_rd"}, {8'h00, rd}, {8'h00, exp_rd});
    chk({tag, "_rdhi"}, {8'h00, rd_hi}, {8'h00, exp_hi});
    chk({tag, "_flags"}, {8'h00, flags}, {8'h00, exp_fl});
    chk({tag, "_inready_busy"}, {15'd0, busy_ready | in_ready}, 16'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle_after"}, {14'd0, in_ready, out_valid}, 16'b10);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    inst      = 8'h00;
    ra        = 8'h00;
    rb        = 8'h00;
    tick();
    chk("reset_ctrl", {14'd0, in_ready, out_valid}, 16'b10);
    chk("reset_data", {rd, rd_hi}, 16'h0000);
    chk("reset_flags", {8'h00, flags}, 16'h0000);
    rst = 1'b0;
    tick();

    // flags are {D,V,N,Z,C} in bits [4:0]
    run_op("add_ovf",     4'b1010, 8'h7F, 8'h01, 1, 8'h80, 8'h00, 8'h0C, 1'b0);
    run_op("add_ovf_rdy", 4'b1010, 8'h7F, 8'h01, 1, 8'h80, 8'h00, 8'h0C, 1'b1);
    run_op("sub_zero",    4'b1011, 8'h05, 8'h05, 1, 8'h00, 8'h00, 8'h03, 1'b0);
    run_op("sub_borrow",  4'b1011, 8'h00, 8'h01, 1, 8'hFF, 8'h00, 8'h04, 1'b0);
    run_op("sub_ovf",     4'b1011, 8'h80, 8'h01, 1, 8'h7F, 8'h00, 8'h09, 1'b0);
    run_op("dec_wrap",    4'b1001, 8'h00, 8'h77, 1, 8'hFF, 8'h00, 8'h04, 1'b0);
    run_op("inc_wrap",    4'b1000, 8'hFF, 8'h77, 1, 8'h00, 8'h00, 8'h03, 1'b0);
    run_op("mulu_max",    4'b0100, 8'hFF, 8'hFF, 9, 8'h01, 8'hFE, 8'h01, 1'b0);
    run_op("mulu_zero",   4'b0100, 8'h00, 8'h05, 9, 8'h00, 8'h00, 8'h02, 1'b0);
    run_op("muls_neg",    4'b0101, 8'hFD, 8'h04, 9, 8'hF4, 8'hFF, 8'h04, 1'b0);
    run_op("muls_minmin", 4'b0101, 8'h80, 8'h80, 9, 8'h00, 8'h40, 8'h08, 1'b0);
    run_op("muls_m1",     4'b0101, 8'hFF, 8'h01, 9, 8'hFF, 8'hFF, 8'h04, 1'b0);
    run_op("unsupported", 4'b0000, 8'h12, 8'h34, 1, 8'h00, 8'h00, 8'h00, 1'b0);
`ifdef SEQ_ALU_DIV_EN
    run_op("divu",        4'b0110, 8'h64, 8'h07, 9, 8'h0E, 8'h02, 8'h00, 1'b0);
    run_op("divu_zero",   4'b0110, 8'h64, 8'h00, 1, 8'hFF, 8'h64, 8'h10, 1'b0);
`else
    run_op("op0110_off",  4'b0110, 8'h64, 8'h07, 1, 8'h00, 8'h00, 8'h00, 1'b0);
`endif

    // Backpressure: result held, new requests ignored until the handshake.
    in_valid = 1'b1;
    inst     = 8'hA0;
    ra       = 8'h7F;
    rb       = 8'h01;
    tick();
    inst = 8'h40;
    ra   = 8'h33;
    rb   = 8'h22;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_data", {rd, flags}, 16'h800C);
      chk("bp_hold_ctrl", {14'd0, in_ready, out_valid}, 16'b01);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release", {14'd0, in_ready, out_valid}, 16'b10);
    chk("bp_no_new_op", {rd, flags}, 16'h800C);

    // Reset during a multiply: everything clears at once and no result appears.
    in_valid = 1'b1;
    inst     = 8'h40;
    ra       = 8'h0F;
    rb       = 8'h0F;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_ctrl", {14'd0, in_ready, out_valid}, 16'b10);
    chk("rst_mid_data", {rd, rd_hi}, 16'h0000);
    chk("rst_mid_flags", {8'h00, flags}, 16'h0000);
    tick();
    rst = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
        if (out_valid) seen = 1'b1;
        tick();
      end
      chk("rst_no_result", {15'd0, seen}, 16'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
